// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- oversampled UART receiver with a small first-word
// fall-through receive FIFO.
//
// Frame format is fixed at elaboration: DATA_BITS data bits (LSB first),
// optional odd/even parity, and STOP_BITS stop bits. Each bit is recovered by
// a three-sample majority vote around mid-bit. Every frame is stored with its
// own parity and framing error flags.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   i_rx_data     asynchronous serial line, idle high
//   o_rx_data     FIFO head data, LSB = first bit received
//   o_rx_valid    FIFO non-empty; head fields valid
//   i_rx_ready    consumer accepts the head while o_rx_valid is high
//   o_parity_err  head frame's parity bit mismatched
//   o_frame_err   head frame had a low vote at a stop-bit position
//   o_overrun     one-cycle pulse: a completed frame was dropped, FIFO full
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_RATE   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_data,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int DIV     = CLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rxs, rxs_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [SC_W-1:0]      sc;
  logic [1:0]           votes;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;

  logic fall, tick, decide, bit_end, voted, last_data, last_stop, push, par_exp;
  logic [ENTRY_W-1:0] entry;

  // Synchronizer plus one extra stage for falling-edge detection. All three
  // reset high so that reset never fabricates a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= i_rx_data;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fall      = rxs_prev & ~rxs;
  assign tick      = (state != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));
  assign decide    = tick && (sc == SC_W'(OVERSAMPLE / 2 + 1));
  assign bit_end   = tick && (sc == SC_W'(OVERSAMPLE - 1));
  // Third sample is taken live at the decision tick.
  assign voted     = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  // Frame completes at the final stop-bit decision, not at its end, so a
  // back-to-back start edge is never missed.
  assign push      = (state == S_STOP) && decide && last_stop;
  assign par_exp   = (PARITY == 1) ? ~^shreg : ^shreg;
  // The current stop vote is folded in here because ferr only updates after
  // this edge.
  assign entry     = {shreg, perr, ferr | ~voted};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state is defaulted before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (fall) state_next = S_START;
      S_START:  if (decide && voted) state_next = S_IDLE;
                else if (bit_end)    state_next = S_DATA;
      S_DATA:   if (bit_end && last_data)
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP:   if (push) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Bit-timing and frame datapath. Counters are held at zero in IDLE so the
  // tick phase restarts from each start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      sc       <= '0;
      votes    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state == S_IDLE) begin
      div_cnt  <= '0;
      sc       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sc <= (sc == SC_W'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;
        if (sc == SC_W'(OVERSAMPLE / 2 - 1)) votes[0] <= rxs;
        if (sc == SC_W'(OVERSAMPLE / 2))     votes[1] <= rxs;
      end
      if (decide) begin
        case (state)
          S_DATA:   shreg <= {voted, shreg[DATA_BITS-1:1]};
          S_PARITY: perr  <= (voted != par_exp);
          S_STOP:   if (!voted) ferr <= 1'b1;
          default:  ;
        endcase
      end
      if (bit_end) begin
        if (state == S_DATA) bit_cnt  <= bit_cnt + 1'b1;
        if (state == S_STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  // Receive FIFO: registered storage read through a mux, so a push is
  // visible at the head on the following cycle.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, pop, wr_en;
  logic [ENTRY_W-1:0] head;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign o_rx_valid = (count != '0);
  assign pop        = o_rx_valid && i_rx_ready;
  // A push while full is only accepted when a pop frees a slot on the same edge.
  assign wr_en      = push && (!full || pop);

  // NOTE: storage is not reset; the head fields are masked while empty so they
  // read 0 after reset and never expose uninitialised entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      o_overrun <= push && !wr_en;
    end
  end

  assign head         = mem[rd_ptr];
  assign o_rx_data    = o_rx_valid ? head[ENTRY_W-1:2] : '0;
  assign o_parity_err = o_rx_valid & head[1];
  assign o_frame_err  = o_rx_valid & head[0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. Three receivers share clock and reset:
//   ch0: 8N1, ch1: 7 data bits even parity, ch2: 8N2.
// The divider is shrunk to 4 clocks per sample tick (64 clocks per bit).
// Expected frames are queued per channel when stimulus is sent and compared
// by a monitor whenever a channel pops its FIFO head.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BAUD    = 9600;
  localparam int OS      = 16;
  localparam int DIV     = 4;
  localparam int CLK_HZ  = BAUD * OS * DIV;
  localparam int BIT_CYC = OS * DIV;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx    [3];
  logic       rdy   [3];
  logic       valid [3];
  logic       perr_o[3];
  logic       ferr_o[3];
  logic       ovr   [3];
  logic [7:0] data0;
  logic [6:0] data1;
  logic [7:0] data2;
  logic [8:0] odata [3];

  int   passed = 0;
  int   total  = 0;
  int   vcnt [3] = '{0, 0, 0};
  int   ocnt [3] = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  assign odata[0] = {1'b0, data0};
  assign odata[1] = {2'b0, data1};
  assign odata[2] = {1'b0, data2};

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .i_rx_data(rx[0]), .o_rx_data(data0), .o_rx_valid(valid[0]),
    .i_rx_ready(rdy[0]), .o_parity_err(perr_o[0]), .o_frame_err(ferr_o[0]), .o_overrun(ovr[0]));

  uart_rx_fifo #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7e1 (
    .clk(clk), .rst(rst), .i_rx_data(rx[1]), .o_rx_data(data1), .o_rx_valid(valid[1]),
    .i_rx_ready(rdy[1]), .o_parity_err(perr_o[1]), .o_frame_err(ferr_o[1]), .o_overrun(ovr[1]));

  uart_rx_fifo #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
    .clk(clk), .rst(rst), .i_rx_data(rx[2]), .o_rx_data(data2), .o_rx_valid(valid[2]),
    .i_rx_ready(rdy[2]), .o_parity_err(perr_o[2]), .o_frame_err(ferr_o[2]), .o_overrun(ovr[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge, well away from sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT_CYC) step();
  endtask

  // Drives one frame on channel ch. rst_at pulses reset for one cycle at that
  // cycle offset into the frame; [glo, ghi) forces the line low as a glitch.
  task automatic send_x(input int ch, input logic [8:0] d, input int nd, input int par,
                        input bit bad_par, input int nstop, input logic [1:0] stop_val,
                        input int rst_at, input int glo, input int ghi);
    logic [15:0] b;
    int          n;
    logic        p;
    b    = '1;
    p    = 1'b0;
    b[0] = 1'b0;
    n    = 1;
    for (int i = 0; i < nd; i++) begin
      b[n] = d[i];
      p    = p ^ d[i];
      n++;
    end
    if (par != 0) begin
      b[n] = ((par == 2) ? p : ~p) ^ bad_par;
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      b[n] = stop_val[i];
      n++;
    end
    for (int i = 0; i < n * BIT_CYC; i++) begin
      rx[ch] = (i >= glo && i < ghi) ? 1'b0 : b[i / BIT_CYC];
      rst    = (i == rst_at);
      step();
    end
    rx[ch] = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic send(input int ch, input logic [8:0] d);
    send_x(ch, d, (ch == 1) ? 7 : 8, (ch == 1) ? 2 : 0, 1'b0,
           (ch == 2) ? 2 : 1, 2'b11, -1, -1, -1);
  endtask

  // Scoreboard monitor: counts valid/overrun cycles and compares every pop.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   sz;
    for (int ch = 0; ch < 3; ch++) begin
      if (valid[ch]) vcnt[ch]++;
      if (ovr[ch])   ocnt[ch]++;
      if (valid[ch] && rdy[ch]) begin
        case (ch)
          0:       sz = q0.size();
          1:       sz = q1.size();
          default: sz = q2.size();
        endcase
        check($sformatf("ch%0d_pop_expected", ch), 32'(sz != 0), 32'd1);
        if (sz != 0) begin
          case (ch)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check($sformatf("ch%0d_data", ch), 32'(odata[ch]), 32'(e.d));
          check($sformatf("ch%0d_parity_err", ch), 32'(perr_o[ch]), 32'(e.pe));
          check($sformatf("ch%0d_frame_err", ch), 32'(ferr_o[ch]), 32'(e.fe));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         v, o;
    logic [8:0] d;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    repeat (3) step();
    @(negedge clk);
    check("rst_valid0", 32'(valid[0]), 0);
    check("rst_data0", 32'(data0), 0);
    check("rst_perr0", 32'(perr_o[0]), 0);
    check("rst_ferr0", 32'(ferr_o[0]), 0);
    check("rst_ovr0", 32'(ovr[0]), 0);
    check("rst_valid1", 32'(valid[1]), 0);
    check("rst_valid2", 32'(valid[2]), 0);
    rst = 1'b0;
    step();
    idle(1);

    // 8N1 single byte: exactly one valid cycle with ready held high.
    v = vcnt[0];
    q0.push_back('{9'h0A5, 1'b0, 1'b0});
    send(0, 9'h0A5);
    idle(2);
    check("a5_drained", 32'(q0.size()), 0);
    check("a5_one_valid_cycle", 32'(vcnt[0] - v), 1);

    // Random bytes with 1..5 bit idle gaps, checked in order by the monitor.
    for (int i = 0; i < 20; i++) begin
      d = 9'($urandom_range(0, 255));
      q0.push_back('{d, 1'b0, 1'b0});
      send(0, d);
      idle($urandom_range(1, 5));
    end
    idle(1);
    check("random_drained", 32'(q0.size()), 0);

    // 7E1: correct parity, then inverted parity bit.
    q1.push_back('{9'h041, 1'b0, 1'b0});
    send(1, 9'h041);
    idle(1);
    q1.push_back('{9'h041, 1'b1, 1'b0});
    send_x(1, 9'h041, 7, 2, 1'b1, 1, 2'b11, -1, -1, -1);
    idle(2);
    check("parity_drained", 32'(q1.size()), 0);

    // Low stop bit, then a clean frame.
    q0.push_back('{9'h03C, 1'b0, 1'b1});
    send_x(0, 9'h03C, 8, 0, 1'b0, 1, 2'b00, -1, -1, -1);
    idle(2);
    q0.push_back('{9'h055, 1'b0, 1'b0});
    send(0, 9'h055);
    idle(2);
    check("frame_err_drained", 32'(q0.size()), 0);

    // Short low pulse on an idle line must be rejected as a false start.
    v = vcnt[0];
    rx[0] = 1'b0;
    repeat (3 * DIV) step();
    rx[0] = 1'b1;
    idle(12);
    check("glitch_no_push", 32'(vcnt[0] - v), 0);

    // One-tick glitch over the middle vote of data bit 2 of 0xFF.
    q0.push_back('{9'h0FF, 1'b0, 1'b0});
    send_x(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11, -1, 3 * BIT_CYC + 34, 3 * BIT_CYC + 38);
    idle(2);
    check("mid_glitch_drained", 32'(q0.size()), 0);

    // Fill the FIFO with ready low; the fifth frame overruns.
    rdy[0] = 1'b0;
    o = ocnt[0];
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back('{9'(i), 1'b0, 1'b0});
      send(0, 9'(i));
      idle(1);
    end
    check("overrun_one_pulse", 32'(ocnt[0] - o), 1);
    @(negedge clk);
    check("full_head_valid", 32'(valid[0]), 1);
    check("full_head_data", 32'(data0), 32'h01);
    step();
    rdy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_valid", 32'(valid[0]), 1);
    end
    @(negedge clk);
    check("burst_valid_fall", 32'(valid[0]), 0);
    check("burst_drained", 32'(q0.size()), 0);
    step();

    // Reset mid-frame: a stored entry and the partial frame are discarded.
    rdy[0] = 1'b0;
    send(0, 9'h077);
    idle(1);
    check("pre_rst_stored", 32'(valid[0]), 1);
    o = ocnt[0];
    send_x(0, 9'h0F0, 8, 0, 1'b0, 1, 2'b11, 5 * BIT_CYC + BIT_CYC / 2, -1, -1);
    idle(2);
    @(negedge clk);
    check("midrst_valid", 32'(valid[0]), 0);
    check("midrst_data", 32'(data0), 0);
    check("midrst_perr", 32'(perr_o[0]), 0);
    check("midrst_ferr", 32'(ferr_o[0]), 0);
    check("midrst_no_overrun", 32'(ocnt[0] - o), 0);
    step();
    rdy[0] = 1'b1;
    v = vcnt[0];
    q0.push_back('{9'h09E, 1'b0, 1'b0});
    send(0, 9'h09E);
    idle(2);
    check("post_rst_drained", 32'(q0.size()), 0);
    check("post_rst_one_valid", 32'(vcnt[0] - v), 1);

    // 8N2: clean frame, then a low second stop bit.
    q2.push_back('{9'h0C3, 1'b0, 1'b0});
    send(2, 9'h0C3);
    idle(1);
    q2.push_back('{9'h05A, 1'b0, 1'b1});
    send_x(2, 9'h05A, 8, 0, 1'b0, 2, 2'b01, -1, -1, -1);
    idle(2);
    check("stop2_drained", 32'(q2.size()), 0);
    check("ch1_no_overrun", 32'(ocnt[1]), 0);
    check("ch2_no_overrun", 32'(ocnt[2]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised successor to the single-byte UART receiver. It adds configurable frame format (5–9 data bits, optional odd/even parity, 1 or 2 stop bits) and oversampled majority-vote bit recovery. Error flags are reported per frame, and a small receive FIFO has a valid/ready output. It sits between the board RX pin and any byte consumer (command parser, DMA, loopback) that cannot guarantee to accept every byte on the cycle it arrives.

## Interface
- CLK_RATE, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bits/s
- OVERSAMPLE, 16, sample ticks per bit, even, ≥8
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, entries, power of 2, ≥2
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_rx_data  in  1  asynchronous serial line, idle high
- o_rx_data  out  DATA_BITS  FIFO head data, LSB = first bit received
- o_rx_valid  out  1  FIFO non-empty; head fields valid
- i_rx_ready  in  1  consumer accepts head when high with o_rx_valid
- o_parity_err  out  1  head frame's parity mismatched (0 when PARITY = 0)
- o_frame_err  out  1  head frame had a low sample at a stop-bit position
- o_overrun  out  1  one-cycle pulse: completed frame dropped, FIFO full

## Operation
- Input: 2-flop synchronizer, both flops reset to 1. All logic uses the synchronized bit `rxs`.
- Tick divider: DIV = CLK_RATE / (BAUD_RATE*OVERSAMPLE), integer division (defaults give 651). The counter is held at 0 in IDLE and restarts on start-edge detection, so tick phase aligns to each frame. `tick` pulses when the count reaches DIV-1, then the count returns to 0.
- Sample counter `sc` runs 0..OVERSAMPLE-1 per bit. The bit value is the majority of `rxs` at sc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, and is decided at sc = OVERSAMPLE/2+1.
- FSM states:
  - IDLE: on `rxs` 1→0, go to START.
  - START: at the decision point, a voted 1 is a false start; go to IDLE with no side effect. A voted 0 waits for the bit end, then goes to DATA.
  - DATA: shift DATA_BITS voted bits in LSB-first. After the last bit, go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: compare the voted bit against the odd/even parity of the data. Set a `perr` latch on mismatch.
  - STOP: vote each stop bit. Any voted 0 sets a `ferr` latch. At the decision point of the final stop bit, push {data, perr, ferr} and go to IDLE immediately; do not wait for the bit end, so back-to-back frames resynchronize.
- FIFO: first-word fall-through, width DATA_BITS+2, pointers wrap modulo FIFO_DEPTH, count range 0..FIFO_DEPTH.
  - Pop when o_rx_valid && i_rx_ready.
  - Push when full with no pop: frame dropped, o_overrun pulses, FIFO contents unchanged.
  - Push while full with a simultaneous pop: accepted, count unchanged, no overrun.
  - Push and pop while empty: not simultaneous. o_rx_valid rises the cycle after the push.
- Break (all-zero data plus low stop) is reported as a frame with o_frame_err = 1. The receiver then waits in IDLE for `rxs` to return high before detecting a new falling edge.

## Timing
- Reset values: o_rx_valid 0, o_rx_data 0, o_parity_err 0, o_frame_err 0, o_overrun 0. FSM IDLE, FIFO empty, synchronizer 1.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied. No push and no o_overrun pulse occur from that frame.
- Input latency: 2 cycles through the synchronizer.
- Push timing: occurs on the tick of the final stop-bit decision point. o_rx_valid and the head fields are registered and are visible the next cycle.
- Handshake: the head fields are stable while o_rx_valid && !i_rx_ready. On a pop, the next entry (if any) appears the following cycle. With ≥2 entries, o_rx_valid stays high, giving a throughput of 1 word/cycle.
- o_overrun is exactly 1 cycle wide per dropped frame.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × OVERSAMPLE × DIV cycles ± one tick. The required tolerance is ±2% baud mismatch at the defaults.

## Test plan
- Defaults (8N1), i_rx_ready = 1, send 0xA5 → one o_rx_valid cycle with o_rx_data = 0xA5 and both error flags 0. Then send 20 random bytes with 1–5 bit gaps → all match, in order.
- DATA_BITS = 7, PARITY = 2: send 0x41 with correct parity → o_parity_err 0. Resend with the parity bit inverted → o_rx_data 0x41 and o_parity_err 1.
- Defaults: send 0x3C with the stop bit driven low → o_frame_err 1. A following 0x55 with a normal stop → 0x55 with no error flags.
- Glitch rejection: a low pulse of 3 sample ticks on an idle line → no push. A 1-tick glitch at the mid-bit sample of data bit 2 of 0xFF → 0xFF received.
- FIFO and overrun: hold i_rx_ready = 0 and send 0x01..0x05 with FIFO_DEPTH = 4 → o_overrun pulses once on the 5th frame. Then raise i_rx_ready → 0x01, 0x02, 0x03, 0x04 pop on consecutive cycles and o_rx_valid falls.
- Pulse rst for 1 cycle midway through data bit 4 → outputs return to their reset values with no push. The next 0x9E is received correctly. STOP_BITS = 2 with a low second stop bit → o_frame_err 1.
